// File: rtl/sample_recorder.sv
// Triggered capture buffer: arms on request, starts recording on a rising
// crossing of trig_level, fills the whole RAM once, and offers registered readback.
module sample_recorder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     arm,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic                     prevValid_q, prevValid_d;
  logic [DATA_WIDTH-1:0]    prevSample_q, prevSample_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DATA_WIDTH-1:0]    dout_q;

  logic                     memWe;
  logic [ADDRESS_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

  always_comb begin
    state_d      = state_q;
    wrAddr_d     = wrAddr_q;
    prevValid_d  = prevValid_q;
    prevSample_d = prevSample_q;
    memWe        = 1'b0;
    memAddr      = wrAddr_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = ARMED;
          prevValid_d = 1'b0;
        end
      end
      ARMED: begin
        if (en) begin
          prevSample_d = din;
          prevValid_d  = 1'b1;
          // Rising crossing needs a real previous sample below the level.
          if (prevValid_q && (prevSample_q < trig_level) && (din >= trig_level)) begin
            memWe    = 1'b1;
            memAddr  = '0;
            wrAddr_d = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (en) begin
          memWe    = 1'b1;
          wrAddr_d = wrAddr_q + 1'b1;
          if (wrAddr_q == {ADDRESS_WIDTH{1'b1}}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (arm) begin
          state_d     = ARMED;
          prevValid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wrAddr_q     <= '0;
      prevValid_q  <= 1'b0;
      prevSample_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrAddr_q     <= wrAddr_d;
      prevValid_q  <= prevValid_d;
      prevSample_q <= prevSample_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // RAM is never cleared; reading with a non-blocking update gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (memWe && !rst) begin
      mem[memAddr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= mem[rd_addr];
    end
  end

  assign dout    = dout_q;
  assign wr_addr = wrAddr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sample_recorder.sv
// Randomized scoreboard bench for sample_recorder: a phase/sample-count model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_sample_recorder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] dout;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  sample_recorder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm),
    .trig_level(trig_level), .rd_addr(rd_addr), .dout(dout),
    .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          doutKnown;
    logic [AW-1:0] wa;
    logic          busy;
    logic          done;
  } expect_t;

  expect_t expQ[$];
  expect_t expItem;
  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 full.
  int            phase = 0;
  int            recCount = 0;
  bit            havePrev = 0;
  logic [DW-1:0] prevS = '0;
  logic [DW-1:0] refMem [DEPTH];
  bit            refKnown [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      refKnown[i] = 1'b0;
      refMem[i] = '0;
    end
  end

  task automatic modelStep(input logic r, input logic e, input logic [DW-1:0] d,
                           input logic a, input logic [DW-1:0] t,
                           input logic [AW-1:0] ra, output expect_t x);
    bit crossing;
    if (r) begin
      x.dout = '0;
      x.doutKnown = 1'b1;
    end else begin
      x.dout = refMem[ra];
      x.doutKnown = refKnown[ra];
    end
    if (r) begin
      phase = 0; recCount = 0; havePrev = 0; prevS = '0;
    end else begin
      case (phase)
        0: if (a) begin phase = 1; havePrev = 0; end
        1: if (e) begin
             crossing = havePrev && (prevS < t) && (d >= t);
             prevS = d;
             havePrev = 1;
             if (crossing) begin
               refMem[0] = d; refKnown[0] = 1'b1;
               recCount = 1; phase = 2;
             end
           end
        2: if (e) begin
             refMem[recCount] = d; refKnown[recCount] = 1'b1;
             recCount++;
             if (recCount == DEPTH) phase = 3;
           end
        default: if (a) begin phase = 1; havePrev = 0; recCount = 0; end
      endcase
    end
    x.wa   = (phase == 2) ? AW'(recCount) : '0;
    x.busy = (phase == 1) || (phase == 2);
    x.done = (phase == 3);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [DW-1:0] d,
                               input logic a, input logic [DW-1:0] t,
                               input logic [AW-1:0] ra);
    expect_t x;
    rst = r; en = e; din = d; arm = a; trig_level = t; rd_addr = ra;
    modelStep(r, e, d, a, t, ra, x);
    expQ.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input expect_t x);
    checks++;
    if (busy !== x.busy) begin
      errors++;
      $display("[TB] FAIL busy at %0t: got %0b expected %0b", $time, busy, x.busy);
    end
    checks++;
    if (done !== x.done) begin
      errors++;
      $display("[TB] FAIL done at %0t: got %0b expected %0b", $time, done, x.done);
    end
    checks++;
    if (wr_addr !== x.wa) begin
      errors++;
      $display("[TB] FAIL wr_addr at %0t: got %0d expected %0d", $time, wr_addr, x.wa);
    end
    if (x.doutKnown) begin
      checks++;
      if (dout !== x.dout) begin
        errors++;
        $display("[TB] FAIL dout at %0t: got 0x%02h expected 0x%02h", $time, dout, x.dout);
      end
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expItem = expQ.pop_front();
      checkOutput(expItem);
    end
  end

  // Feeds random samples with random en gaps until the model leaves recording.
  task automatic finishCapture(input logic [DW-1:0] t, input bit allowArm);
    for (int i = 0; i < 4 * DEPTH && phase == 2; i++) begin
      logic e;
      logic [AW-1:0] ra;
      e = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? AW'(recCount) : AW'($urandom);
      applyStimulus(1'b0, e, DW'($urandom), allowArm && ($urandom_range(0, 9) == 0), t, ra);
    end
  endtask

  task automatic readAll(input int n);
    for (int a = 0; a <= n; a++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 8'h80, AW'(a));
    end
  endtask

  initial begin
    $display("[TB] start");
    // Reset with arm and en held high; arm must be swallowed.
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 8'h80, '0);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 8'h80, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h90, 1'b0, 8'h80, '0);

    // Trigger crossing sequence, then fill the rest randomly.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h80, '0);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 8'h80, '0);
    applyStimulus(1'b0, 1'b1, 8'h70, 1'b0, 8'h80, '0);
    applyStimulus(1'b0, 1'b1, 8'h90, 1'b0, 8'h80, '0);
    applyStimulus(1'b0, 1'b1, 8'hA0, 1'b0, 8'h80, '0);
    applyStimulus(1'b0, 1'b0, 8'hA0, 1'b0, 8'h80, '0);
    finishCapture(8'h80, 1'b1);
    readAll(DEPTH - 1);

    // Armed with samples already at or above the level: never triggers.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h80, '0);
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] d;
      d = (i < 150) ? 8'hF0 : DW'($urandom_range(8'h80, 8'hFF));
      applyStimulus(1'b0, 1'b1, d, 1'b0, 8'h80, AW'($urandom));
    end

    // Boundary: prev just below, din exactly at level triggers; then ramp with en toggling.
    applyStimulus(1'b0, 1'b1, 8'h7F, 1'b0, 8'h80, '0);
    applyStimulus(1'b0, 1'b1, 8'h80, 1'b0, 8'h80, '0);
    for (int k = 1; k < 2 * DEPTH && phase == 2; k++) begin
      logic [AW-1:0] ra;
      ra = (recCount == 5 || (k % 7) == 0) ? AW'(recCount) : AW'($urandom);
      if (k % 2 == 1) applyStimulus(1'b0, 1'b1, DW'(8'h80 + recCount), 1'b0, 8'h80, ra);
      else            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h80, ra);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 8'h80, '0);
    readAll(DEPTH - 1);

    // Arm during capture is ignored; reset at write pointer 100 abandons capture.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, '0);
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 8'h40, '0);
    applyStimulus(1'b0, 1'b1, 8'h50, 1'b0, 8'h40, '0);
    for (int i = 0; i < 1000 && phase == 2 && recCount < 100; i++) begin
      applyStimulus(1'b0, 1'b1, DW'($urandom), (recCount == 50), 8'h40, AW'(recCount));
    end
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, 8'h40, '0);
    readAll(99);

    // Free-running random traffic with occasional reset and arm.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                    DW'($urandom), ($urandom_range(0, 39) == 0),
                    DW'($urandom_range(8'h20, 8'hE0)), AW'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
